adc_spram_writer: RTL
=====================

Name: adc_spram_writer

Overview:
- Downstream stage of the ADC sample FIFO. On a start command it drains samples from the FIFO and writes them linearly into NUM_BANKS single-port RAM banks.
- Bank is chosen from the upper bits of a linear sample counter, word address from the lower bits.
- Signals done when the requested capture length is stored or on abort; the readout logic then takes over the banks.

Parameters:
- DATA_WIDTH, 16, sample width; matches FIFO data width.
- ADDR_WIDTH, 14, word address bits per bank (16384 words).
- NUM_BANKS, 4, number of RAM banks; power of two, minimum 1.
- BANK_BITS, $clog2(NUM_BANKS) (0 when NUM_BANKS=1), derived bank-select width.
- LEN_W, ADDR_WIDTH+BANK_BITS+1, capture length and counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle capture request
- abort  in  1  stop capture early
- capture_len  in  LEN_W  samples to store, sampled on an accepted start
- fifo_empty  in  1  FIFO empty flag, registered in the FIFO
- fifo_data  in  DATA_WIDTH  FIFO data output, valid 1 cycle after fifo_rd_en
- fifo_rd_en  out  1  FIFO read strobe
- fifo_flush  out  1  FIFO reset pulse
- mem_addr  out  ADDR_WIDTH  shared bank word address
- mem_din  out  DATA_WIDTH  shared bank write data
- mem_we  out  NUM_BANKS  one-hot per-bank write enable
- busy  out  1  capture in progress
- done  out  1  sticky completion flag
- samples_stored  out  LEN_W  count of samples written

Behaviour:
- Reset values: all outputs 0, FSM in IDLE.
- Reset mid-capture: immediate IDLE, no further writes; RAM contents are left unchanged.
- Start handling: start is accepted only in IDLE or DONE and is ignored while busy.
- On accepted start:
  - latch length; 0, or any value above NUM_BANKS*2^ADDR_WIDTH, becomes the full capacity;
  - clear samples_stored and done;
  - pulse fifo_flush for 1 cycle.
- FSM states: IDLE, FLUSH, WAIT, READ, WRITE, DONE.
- IDLE / DONE: on accepted start, go to FLUSH.
- FLUSH: lasts 2 cycles (FIFO count clears, then its empty register updates); then go to WAIT.
- WAIT: if samples_stored == len, go to DONE. Else if !fifo_empty, go to READ. Else stay.
- READ: fifo_rd_en=1 for exactly this cycle; go to WRITE.
- WRITE:
  - fifo_data is valid; drive mem_din=fifo_data and mem_addr=samples_stored[ADDR_WIDTH-1:0];
  - mem_we bit at index samples_stored[ADDR_WIDTH+:BANK_BITS] = 1 (bit 0 when NUM_BANKS=1);
  - samples_stored increments at the end of this cycle; go to WAIT.
- DONE: busy=0, done=1; hold until the next accepted start.
- busy=1 in FLUSH, WAIT, READ and WRITE.
- Read spacing: fifo_rd_en pulses are separated by at least 2 idle cycles, so fifo_empty is always current when sampled in WAIT. Throughput is 1 sample per 3 clk minimum.
- mem_we is combinational from the WRITE state; mem_addr and mem_din are stable throughout that cycle; mem_we=0 in every other state.
- Bank wrap: address 2^ADDR_WIDTH-1 of bank k is followed by address 0 of bank k+1. There is no wrap past the last bank, since the capacity clamp stops first.
- abort:
  - in WAIT or FLUSH: go to DONE;
  - in READ: complete the following WRITE, then go to DONE.
  - An in-flight sample is never lost.
- Simultaneous start and abort in IDLE: start wins, abort is ignored.
- No overflow detection here; FIFO full is the upstream concern.

Decomposition:
- Shared package: FSM state encoding, and the capacity constant computed from ADDR_WIDTH/NUM_BANKS (the LEN_W and BANK_BITS derivation).
- One natural sub-module: spram_bank_decode (combinational linear index -> bank one-hot + word address), reused by the readout block.

Test Plan:
- Basic: NUM_BANKS=4, capture_len=5, FIFO preloaded with 0x1000..0x1004 -> addresses 0..4 of bank 0 written with those values; done=1, samples_stored=5; fifo_rd_en never asserted on adjacent or 1-gap cycles.
- Bank crossing: capture_len=16386 -> last write to bank 0 is address 16383; next two writes go to bank 1 addresses 0 and 1; mem_we=4'b0010 on those writes.
- Empty stall: FIFO fed 1 sample every 20 clk, capture_len=3 -> FSM idles in WAIT, no rd_en while empty, exactly 3 writes.
- Length clamp: capture_len=0 and separately capture_len=70000 -> stops at 65536 samples; last write is bank 3 address 16383.
- Abort in READ: assert abort during the READ cycle of sample 2 -> sample 2 still written; done=1, samples_stored=3.
- Reset / restart:
  - reset asserted during WRITE of sample 7 -> all outputs 0 next cycle;
  - start while busy is ignored;
  - start from DONE produces a fifo_flush pulse and samples_stored=0.

Source files
------------

// File: rtl/adc_spram_writer_pkg.sv
// Shared definitions for the ADC sample writer and its bank decoder:
// FSM state encoding and the geometry helpers that derive bank-select
// width, counter width and total capture capacity from the RAM shape.
package adc_spram_writer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_WAIT,
      ST_READ,
      ST_WRITE,
      ST_DONE
   } state_t;

   // Bank-select width; a single bank needs no select bits.
   function automatic int unsigned bank_bits_f(input int unsigned num_banks);
      return (num_banks <= 1) ? 0 : $clog2(num_banks);
   endfunction

   // Counter width: one extra bit so the full capacity itself is representable.
   function automatic int unsigned len_w_f(input int unsigned addr_width,
                                           input int unsigned num_banks);
      return addr_width + bank_bits_f(num_banks) + 1;
   endfunction

   // Total words across all banks.
   function automatic longint unsigned capacity_f(input int unsigned addr_width,
                                                  input int unsigned num_banks);
      return longint'(num_banks) << addr_width;
   endfunction

endpackage

// File: rtl/adc_spram_writer_bank_decode.sv
// Linear sample index -> one-hot bank enable plus word address within the
// bank. Purely combinational; shared with the readout side.
module spram_bank_decode
   import adc_spram_writer_pkg::*;
#(
   parameter int ADDR_WIDTH = 14,
   parameter int NUM_BANKS  = 4,
   parameter int BANK_BITS  = bank_bits_f(NUM_BANKS)
) (
   input  logic [ADDR_WIDTH+BANK_BITS-1:0] i_index,
   output logic [NUM_BANKS-1:0]            o_bank_we,
   output logic [ADDR_WIDTH-1:0]           o_word_addr
);

   assign o_word_addr = i_index[ADDR_WIDTH-1:0];

   generate
      if (NUM_BANKS == 1) begin : g_single
         assign o_bank_we = 1'b1;
      end else begin : g_multi
         assign o_bank_we = NUM_BANKS'(1) << i_index[ADDR_WIDTH +: BANK_BITS];
      end
   endgenerate

endmodule

// File: rtl/adc_spram_writer.sv
// Drains the ADC sample FIFO into NUM_BANKS single-port RAM banks, filling
// them linearly (bank from upper counter bits, word from lower bits).
// Raises a sticky done when the requested length is stored or on abort.
module adc_spram_writer
   import adc_spram_writer_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 14,
   parameter int NUM_BANKS  = 4,
   parameter int BANK_BITS  = bank_bits_f(NUM_BANKS),
   parameter int LEN_W      = ADDR_WIDTH + BANK_BITS + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [LEN_W-1:0]      capture_len,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic                  fifo_flush,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_din,
   output logic [NUM_BANKS-1:0]  mem_we,
   output logic                  busy,
   output logic                  done,
   output logic [LEN_W-1:0]      samples_stored
);

   localparam logic [LEN_W-1:0] CAPACITY = LEN_W'(capacity_f(ADDR_WIDTH, NUM_BANKS));

   state_t                r_state;
   logic [LEN_W-1:0]      r_len;
   logic [LEN_W-1:0]      r_stored;
   logic                  r_flush_phase;
   logic                  r_abort_pend;
   logic                  r_rd_en;
   logic                  r_flush;
   logic                  r_busy;
   logic                  r_done;

   logic [LEN_W-1:0]      w_len_clamped;
   logic [NUM_BANKS-1:0]  w_bank_we;
   logic [ADDR_WIDTH-1:0] w_word_addr;
   logic [NUM_BANKS-1:0]  w_mem_we;
   logic [ADDR_WIDTH-1:0] w_mem_addr;
   logic [DATA_WIDTH-1:0] w_mem_din;

   assign w_len_clamped = ((capture_len == '0) || (capture_len > CAPACITY)) ?
                          CAPACITY : capture_len;

   spram_bank_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .NUM_BANKS  (NUM_BANKS),
      .BANK_BITS  (BANK_BITS)
   ) u_decode (
      .i_index     (r_stored[LEN_W-2:0]),
      .o_bank_we   (w_bank_we),
      .o_word_addr (w_word_addr)
   );

   // Capture sequencer: flush, then alternate wait/read/write until length or abort.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_len         <= '0;
         r_stored      <= '0;
         r_flush_phase <= 1'b0;
         r_abort_pend  <= 1'b0;
         r_rd_en       <= 1'b0;
         r_flush       <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_rd_en <= 1'b0;
         r_flush <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               // start beats a simultaneous abort: abort is not looked at here
               if (start) begin
                  r_state       <= ST_FLUSH;
                  r_len         <= w_len_clamped;
                  r_stored      <= '0;
                  r_done        <= 1'b0;
                  r_busy        <= 1'b1;
                  r_flush       <= 1'b1;
                  r_flush_phase <= 1'b0;
                  r_abort_pend  <= 1'b0;
               end
            end
            ST_FLUSH: begin
               if (abort) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else if (r_flush_phase) begin
                  r_state <= ST_WAIT;
               end else begin
                  r_flush_phase <= 1'b1;
               end
            end
            ST_WAIT: begin
               if ((r_stored == r_len) || abort) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else if (!fifo_empty) begin
                  r_state <= ST_READ;
                  r_rd_en <= 1'b1;
               end
            end
            ST_READ: begin
               r_state <= ST_WRITE;
               if (abort) r_abort_pend <= 1'b1;
            end
            ST_WRITE: begin
               r_stored <= r_stored + 1'b1;
               // the sample fetched in READ is committed before honouring abort
               if (r_abort_pend || abort) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // RAM port is live only in WRITE; otherwise held at zero.
   always_comb begin
      w_mem_we   = '0;
      w_mem_addr = '0;
      w_mem_din  = '0;
      if (r_state == ST_WRITE) begin
         w_mem_we   = w_bank_we;
         w_mem_addr = w_word_addr;
         w_mem_din  = fifo_data;
      end
   end

   assign fifo_rd_en     = r_rd_en;
   assign fifo_flush     = r_flush;
   assign mem_we         = w_mem_we;
   assign mem_addr       = w_mem_addr;
   assign mem_din        = w_mem_din;
   assign busy           = r_busy;
   assign done           = r_done;
   assign samples_stored = r_stored;

endmodule
